dual_port_ram_be: RTL and testbench
===================================

// Module: dual_port_ram_be
// PURPOSE
//   Next-generation true dual-port RAM for the processor datapath (register file, scratch/data memory).
//   Two independent read/write ports share one clock. The block adds:
//   - per-byte write enables
//   - a selectable read-during-write mode
//   - an optional output pipeline register
//   - optional hardwired-zero location 0
//   - a hardware clear sequencer that zeroes the array after reset or on request
// PARAMETERS
//   DATA_WIDTH  32  word width in bits; must be an integer multiple of BYTE_WIDTH
//   ADDR_WIDTH  5   address width; depth = 2**ADDR_WIDTH
//   BYTE_WIDTH  8   bits per byte lane; NBE = DATA_WIDTH/BYTE_WIDTH
//   RD_MODE     0   0 = read-first (old data), 1 = write-first (new, merged data)
//   OUT_REG     0   0 = read latency 1 cycle, 1 = read latency 2 cycles
//   ZERO_LOC0   1   1 = address 0 always reads 0 and writes to it are dropped
// PORTS
//   iClk        in   1            single clock; all logic on the rising edge
//   iRst_n      in   1            synchronous, active-low reset
//   iClear      in   1            request re-clear of the whole array (honoured only in READY)
//   iAddrA      in   ADDR_WIDTH   port A address
//   iDataA      in   DATA_WIDTH   port A write data
//   iEnA        in   1            port A access enable
//   iWeA        in   1            port A write enable (qualified by iEnA)
//   iBeA        in   NBE          port A byte-lane enables (qualified by iEnA & iWeA)
//   iAddrB/iDataB/iEnB/iWeB/iBeB  same as port A, for port B
//   oDataA      out  DATA_WIDTH   port A read data
//   oValidA     out  1            oDataA holds the result of an accepted access
//   oDataB/oValidB                same as port A, for port B
//   oBusy       out  1            clear sequence in progress; all port accesses ignored
//   oCollision  out  1            registered pulse: both ports wrote the same address last cycle
// BEHAVIOUR
//   FSM states: CLEAR, READY.
//   - Reset (iRst_n=0 at an edge): state<=CLEAR, clear counter<=0, oBusy<=1.
//     Also on reset: oDataA/B<=0, oValidA/B<=0, oCollision<=0, output pipeline regs<=0.
//   - CLEAR: each cycle write 0 to ram[cnt], then cnt<=cnt+1. When cnt==2**ADDR_WIDTH-1, go to READY with oBusy<=0.
//     A clear takes exactly 2**ADDR_WIDTH cycles. iEn*/iWe*/iClear are ignored; oValidA/B stay 0.
//   - READY: iClear=1 -> CLEAR with cnt<=0 and oBusy<=1 next cycle. An access presented in that same cycle IS performed.
//   - Reset asserted mid-clear restarts the clear from cnt=0.
//   Accepted access: iEnX=1 in READY.
//   - Write: for each lane i with iBeX[i]=1, ram[addr] lane i <= iDataX lane i. Other lanes unchanged.
//     iWeX=1 with iBeX=0 writes nothing but still reads.
//   - Read: every accepted access (read or write) returns data.
//     OUT_REG=0: oDataX and oValidX update at the edge after acceptance (latency 1).
//     OUT_REG=1: one extra register stage (latency 2), valid pipelined alongside data.
//     On a cycle without acceptance, oValidX<=0 and oDataX holds its previous value.
//   Read-during-write, applied per byte lane, for both same-port and cross-port address matches:
//   - RD_MODE=0: the read returns the pre-write contents.
//   - RD_MODE=1: the read returns the contents after all writes of that cycle are applied.
//   Write/write collision (both ports write the same address in the same cycle):
//   - Lanes enabled by both ports take port A data; lanes enabled by only one port take that port's data.
//   - oCollision=1 for exactly the next cycle; otherwise oCollision=0.
//   ZERO_LOC0=1:
//   - Reads of address 0 return 0 in all modes; writes to address 0 are dropped.
//   - A write/write collision at address 0 still pulses oCollision.
//   Address width is exact; no wrap logic is needed. Addresses outside the range cannot occur.
// TESTING
//   1. Reset, then hold iRst_n=1 -> oBusy=1 for exactly 32 cycles, then 0. A read of every address returns 0.
//   2. A: write 0xDEADBEEF to addr 3 with BE=4'hF, then BE=4'b0010 with data 0x0000AA00. Read addr 3 -> 0xDEADAAEF at latency 1 (latency 2 with OUT_REG=1).
//   3. RD_MODE=0: addr 5 holds 0x11111111. A writes 0x22222222 to addr 5 while B reads addr 5 -> oDataB=0x11111111. Repeat with RD_MODE=1 -> 0x22222222.
//   4. Same cycle: A writes 0xAAAAAAAA with BE=4'b0011 and B writes 0xBBBBBBBB with BE=4'b0110, both to addr 7 -> ram[7]=0x00BBAAAA, oCollision pulses for 1 cycle.
//   5. ZERO_LOC0=1: write 0xFFFFFFFF to addr 0 -> a later read returns 0x00000000.
//   6. Write addr 9 = 0x5, assert iClear -> oBusy=1 for 32 cycles and accesses are ignored (oValid=0). Pull iRst_n low at cycle 10 of the clear -> clear restarts. Afterwards addr 9 reads 0.

Source files
------------

// File: rtl/dual_port_ram_be.sv
// Purpose: true dual-port RAM with byte enables, selectable read-during-write and a hardware clear sequencer.
// Latency: read data 1 cycle after acceptance (OUT_REG=0) or 2 cycles (OUT_REG=1).
// Backpressure: none; accesses presented while oBusy=1 (clearing) are silently dropped.
module dual_port_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYTE_WIDTH = 8,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  parameter int ZERO_LOC0  = 1,
  localparam int NBE       = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iClear,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [DATA_WIDTH-1:0] iDataA,
  input  logic                  iEnA,
  input  logic                  iWeA,
  input  logic [NBE-1:0]        iBeA,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iDataB,
  input  logic                  iEnB,
  input  logic                  iWeB,
  input  logic [NBE-1:0]        iBeB,
  output logic [DATA_WIDTH-1:0] oDataA,
  output logic                  oValidA,
  output logic [DATA_WIDTH-1:0] oDataB,
  output logic                  oValidB,
  output logic                  oBusy,
  output logic                  oCollision
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  acc_a, acc_b, wr_a, wr_b;
  logic                  zero_a, zero_b;
  logic [DATA_WIDTH-1:0] merged_a, merged_b;
  logic [DATA_WIDTH-1:0] rd_a_dat, rd_b_dat;

  logic [DATA_WIDTH-1:0] s1_dat_a, s1_dat_b, s2_dat_a, s2_dat_b;
  logic                  s1_vld_a, s1_vld_b, s2_vld_a, s2_vld_b;

  // Access qualification: only READY accepts port traffic.
  always_comb begin
    acc_a  = (state == READY) && iEnA;
    acc_b  = (state == READY) && iEnB;
    wr_a   = acc_a && iWeA;
    wr_b   = acc_b && iWeB;
    zero_a = (ZERO_LOC0 != 0) && (iAddrA == '0);
    zero_b = (ZERO_LOC0 != 0) && (iAddrB == '0);
  end

  // Post-write word seen at each port's address; port A lanes are applied last so A wins shared lanes.
  always_comb begin
    merged_a = mem[iAddrA];
    merged_b = mem[iAddrB];
    for (int i = 0; i < NBE; i++) begin
      if (wr_b && iBeB[i] && (iAddrB == iAddrA))
        merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = iDataB[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr_a && iBeA[i])
        merged_a[i*BYTE_WIDTH +: BYTE_WIDTH] = iDataA[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr_b && iBeB[i])
        merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = iDataB[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (wr_a && iBeA[i] && (iAddrA == iAddrB))
        merged_b[i*BYTE_WIDTH +: BYTE_WIDTH] = iDataA[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Read data selection: old contents or merged contents, with location 0 forced to zero.
  always_comb begin
    rd_a_dat = (RD_MODE != 0) ? merged_a : mem[iAddrA];
    rd_b_dat = (RD_MODE != 0) ? merged_b : mem[iAddrB];
    if (zero_a) rd_a_dat = '0;
    if (zero_b) rd_b_dat = '0;
  end

  // Array update: the clear sequencer owns the array in CLEAR, the ports own it in READY.
  always_ff @(posedge iClk) begin
    if (iRst_n) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= '0;
      end else begin
        if (wr_a && !zero_a) mem[iAddrA] <= merged_a;
        if (wr_b && !zero_b) mem[iAddrB] <= merged_b;
      end
    end
  end

  // Clear sequencer FSM: one location per cycle, then READY until the next clear request.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      oBusy   <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state <= READY;
            oBusy <= 1'b0;
          end
        end
        READY: begin
          if (iClear) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            oBusy   <= 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          oBusy   <= 1'b1;
        end
      endcase
    end
  end

  // First read stage: data captured only on acceptance, otherwise held.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      s1_dat_a <= '0;
      s1_dat_b <= '0;
      s1_vld_a <= 1'b0;
      s1_vld_b <= 1'b0;
    end else begin
      s1_vld_a <= acc_a;
      s1_vld_b <= acc_b;
      if (acc_a) s1_dat_a <= rd_a_dat;
      if (acc_b) s1_dat_b <= rd_b_dat;
    end
  end

  // Optional second read stage: advances only behind a valid first stage so data holds between reads.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      s2_dat_a <= '0;
      s2_dat_b <= '0;
      s2_vld_a <= 1'b0;
      s2_vld_b <= 1'b0;
    end else begin
      s2_vld_a <= s1_vld_a;
      s2_vld_b <= s1_vld_b;
      if (s1_vld_a) s2_dat_a <= s1_dat_a;
      if (s1_vld_b) s2_dat_b <= s1_dat_b;
    end
  end

  // Collision flag: both ports wrote the same address in the previous cycle (address 0 included).
  always_ff @(posedge iClk) begin
    if (!iRst_n) oCollision <= 1'b0;
    else         oCollision <= wr_a && wr_b && (iAddrA == iAddrB);
  end

  assign oDataA  = (OUT_REG != 0) ? s2_dat_a : s1_dat_a;
  assign oDataB  = (OUT_REG != 0) ? s2_dat_b : s1_dat_b;
  assign oValidA = (OUT_REG != 0) ? s2_vld_a : s1_vld_a;
  assign oValidB = (OUT_REG != 0) ? s2_vld_b : s1_vld_b;

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances share stimulus (read-first/latency 1 and write-first/latency 2).
// Expected read data comes from a reference memory and is queued with its due cycle.
// Outputs are sampled on the falling clock edge.
module tb_dual_port_ram_be;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;

  logic [31:0] d0a, d0b, d1a, d1b;
  logic        v0a, v0b, v1a, v1b, busy0, busy1, coll0, coll1;

  always #5 clk = ~clk;

  dual_port_ram_be #(.RD_MODE(0), .OUT_REG(0), .ZERO_LOC0(1)) dut0 (
    .iClk(clk), .iRst_n(rst_n), .iClear(clr),
    .iAddrA(addr_a), .iDataA(data_a), .iEnA(en_a), .iWeA(we_a), .iBeA(be_a),
    .iAddrB(addr_b), .iDataB(data_b), .iEnB(en_b), .iWeB(we_b), .iBeB(be_b),
    .oDataA(d0a), .oValidA(v0a), .oDataB(d0b), .oValidB(v0b),
    .oBusy(busy0), .oCollision(coll0));

  dual_port_ram_be #(.RD_MODE(1), .OUT_REG(1), .ZERO_LOC0(1)) dut1 (
    .iClk(clk), .iRst_n(rst_n), .iClear(clr),
    .iAddrA(addr_a), .iDataA(data_a), .iEnA(en_a), .iWeA(we_a), .iBeA(be_a),
    .iAddrB(addr_b), .iDataB(data_b), .iEnB(en_b), .iWeB(we_b), .iBeB(be_b),
    .oDataA(d1a), .oValidA(v1a), .oDataB(d1b), .oValidB(v1b),
    .oBusy(busy1), .oCollision(coll1));

  typedef struct {
    int          due;
    int          sid;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb[$];
  int          coll_q[$];
  logic [31:0] mem_m [32];
  bit          m_ready = 1'b0;
  bit          mon_en  = 1'b0;
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = dat[i*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: each stream must be valid exactly when an entry is due, with matching data.
  always @(negedge clk) begin
    logic        v [4];
    logic [31:0] d [4];
    bit          found;
    int          i;
    if (mon_en) begin
      v[0] = v0a; v[1] = v0b; v[2] = v1a; v[3] = v1b;
      d[0] = d0a; d[1] = d0b; d[2] = d1a; d[3] = d1b;
      for (int s = 0; s < 4; s++) begin
        found = 1'b0;
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].due == cyc && sb[k].sid == s) begin
            check_val($sformatf("rd_dat_s%0d", s), d[s], sb[k].dat);
            sb.delete(k);
            found = 1'b1;
            break;
          end
        end
        check_val($sformatf("rd_vld_s%0d", s), {31'd0, v[s]}, {31'd0, found});
      end
      i = 0;
      while (i < sb.size()) begin
        if (sb[i].due < cyc) begin
          check_val($sformatf("missing_s%0d", sb[i].sid), 32'd0, 32'd1);
          sb.delete(i);
        end else begin
          i++;
        end
      end
      found = (coll_q.size() > 0) && (coll_q[0] == cyc);
      if (found) void'(coll_q.pop_front());
      check_val("coll0", {31'd0, coll0}, {31'd0, found});
      check_val("coll1", {31'd0, coll1}, {31'd0, found});
    end
  end

  // Drive one cycle of stimulus and record what the reference memory predicts.
  task automatic drive(input logic ea, input logic wa, input logic [4:0] aa, input logic [31:0] da,
                       input logic [3:0] ba, input logic eb, input logic wb, input logic [4:0] ab,
                       input logic [31:0] db, input logic [3:0] bb, input logic c);
    logic [31:0] nm [32];
    @(negedge clk);
    en_a = ea; we_a = wa; addr_a = aa; data_a = da; be_a = ba;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db; be_b = bb;
    clr = c;
    if (m_ready) begin
      nm = mem_m;
      if (eb && wb && ab != 5'd0) nm[ab] = lanes(nm[ab], db, bb);
      if (ea && wa && aa != 5'd0) nm[aa] = lanes(nm[aa], da, ba);
      if (ea) begin
        sb.push_back('{cyc + 1, 0, mem_m[aa]});
        sb.push_back('{cyc + 2, 2, nm[aa]});
      end
      if (eb) begin
        sb.push_back('{cyc + 1, 1, mem_m[ab]});
        sb.push_back('{cyc + 2, 3, nm[ab]});
      end
      if (ea && wa && eb && wb && aa == ab) coll_q.push_back(cyc + 1);
      mem_m = nm;
      if (c) m_ready = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 5'd0, 32'd0, 4'd0, 0, 0, 5'd0, 32'd0, 4'd0, 0);
  endtask

  task automatic rd_a(input logic [4:0] a);
    drive(1, 0, a, 32'd0, 4'd0, 0, 0, 5'd0, 32'd0, 4'd0, 0);
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [31:0] dat, input logic [3:0] be);
    drive(1, 1, a, dat, be, 0, 0, 5'd0, 32'd0, 4'd0, 0);
  endtask

  // Reset for one edge, check reset outputs, then measure the clear sequence length.
  task automatic reset_and_clear(input string tag);
    int n;
    @(negedge clk);
    rst_n = 1'b0; clr = 1'b0; en_a = 1'b0; en_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    check_val({tag, "_rst_d0a"}, d0a, 32'd0);
    check_val({tag, "_rst_d1b"}, d1b, 32'd0);
    check_val({tag, "_rst_vld"}, {28'd0, v0a, v0b, v1a, v1b}, 32'd0);
    check_val({tag, "_rst_coll"}, {30'd0, coll0, coll1}, 32'd0);
    check_val({tag, "_rst_busy"}, {30'd0, busy0, busy1}, 32'd3);
    rst_n = 1'b1;
    n = 0;
    while (busy0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_busy_len"}, n, 32'd32);
    check_val({tag, "_busy1_done"}, {31'd0, busy1}, 32'd0);
    for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
    m_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; clr = 1'b0;
    en_a = 0; we_a = 0; addr_a = 0; data_a = 0; be_a = 0;
    en_b = 0; we_b = 0; addr_b = 0; data_b = 0; be_b = 0;

    // Power-up clear, then every location reads zero on both ports.
    reset_and_clear("init");
    mon_en = 1'b1;
    for (int i = 0; i < 32; i++)
      drive(1, 0, 5'(i), 32'd0, 4'd0, 1, 0, 5'(31 - i), 32'd0, 4'd0, 0);
    idle(3);

    // Byte-lane merge at address 3.
    wr_a(5'd3, 32'hDEADBEEF, 4'hF);
    wr_a(5'd3, 32'h0000AA00, 4'b0010);
    rd_a(5'd3);
    idle(3);

    // Cross-port and same-port read-during-write at address 5.
    wr_a(5'd5, 32'h11111111, 4'hF);
    drive(1, 1, 5'd5, 32'h22222222, 4'hF, 1, 0, 5'd5, 32'd0, 4'd0, 0);
    drive(1, 1, 5'd5, 32'h33333333, 4'b0000, 1, 0, 5'd5, 32'd0, 4'd0, 0);
    idle(3);

    // Write/write collision with partially overlapping lanes at address 7.
    drive(1, 1, 5'd7, 32'hAAAAAAAA, 4'b0011, 1, 1, 5'd7, 32'hBBBBBBBB, 4'b0110, 0);
    rd_a(5'd7);
    drive(1, 1, 5'd8, 32'hCAFEF00D, 4'hF, 1, 1, 5'd8, 32'h12345678, 4'hF, 0);
    drive(1, 0, 5'd8, 32'd0, 4'd0, 1, 1, 5'd7, 32'h99999999, 4'b1000, 0);
    idle(3);

    // Hardwired zero location, including a collision there.
    wr_a(5'd0, 32'hFFFFFFFF, 4'hF);
    rd_a(5'd0);
    drive(1, 1, 5'd0, 32'h1, 4'hF, 1, 1, 5'd0, 32'h2, 4'hF, 0);
    idle(3);

    // Random mixed traffic over a small address window.
    for (int i = 0; i < 80; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom_range(0, 1),
            5'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 0);
    idle(3);

    // Re-clear request: same-cycle access still served, later accesses ignored, reset restarts it.
    wr_a(5'd9, 32'h00000005, 4'hF);
    rd_a(5'd9);
    drive(1, 0, 5'd9, 32'd0, 4'd0, 1, 0, 5'd3, 32'd0, 4'd0, 1);
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 5'd9, 32'hFFFFFFFF, 4'hF, 1, 0, 5'd9, 32'd0, 4'd0, 1);
      check_val($sformatf("clr_busy_%0d", i), {30'd0, busy0, busy1}, 32'd3);
    end
    reset_and_clear("mid");
    drive(1, 0, 5'd9, 32'd0, 4'd0, 1, 0, 5'd3, 32'd0, 4'd0, 0);
    idle(4);

    check_val("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
